// File: rtl/seq_detect_prog_if.sv
// -----------------------------------------------------------------------------
// seq_detect_prog_if
// Groups the serial-input, configuration and result signals of seq_detect_prog.
//   din_valid / din                      : qualified serial data bit
//   cfg_load / cfg_pattern / cfg_len /
//   cfg_overlap                          : run-time pattern configuration
//   cnt_clr                              : match counter clear
//   dout / match_count / cfg_err         : detector results
// Modports:
//   master : the block feeding bits/config and reading results
//   slave  : the detector itself
// -----------------------------------------------------------------------------
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  dout, match_count, cfg_err
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output dout, match_count, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
// Programmable Moore sequence detector. A qualified serial bit stream is shifted
// into a history register and compared against a run-time loaded pattern of
// 1..MAX_LEN bits (oldest pattern bit at [len-1], newest at [0]). Matches raise
// the registered dout flag and bump a saturating match counter. Reset defaults
// reproduce the legacy overlapping "1010" detector.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : seq_detect_prog_if.slave (data, config, counter clear, results)
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_prog_if.slave bus
);

  typedef enum logic {SEARCH = 1'b0, MATCH = 1'b1} state_t;

  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(4'b1010);
  localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(4);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0]   fill_q,  fill_d;
  logic [MAX_LEN-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               ovl_q,   ovl_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               err_q,   err_d;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               cfg_legal;
  logic               hit;

  assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);

  // NOTE: every signal written here gets a default first, so no path through
  // the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    hit     = 1'b0;

    shifted  = {hist_q[MAX_LEN-2:0], bus.din};
    // One extra bit so "fill + 1" never wraps when fill sits at MAX_LEN.
    fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    // Only the low len bits of history/pattern take part in the compare.
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    if (bus.cfg_load) begin
      // A load always swallows a same-cycle data bit, even when rejected.
      if (cfg_legal) begin
        pat_d   = bus.cfg_pattern;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = SEARCH;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.din_valid) begin
      hist_d = shifted;
      fill_d = (fill_q == MAX_LEN_L) ? fill_q : fill_inc[LEN_W-1:0];
      hit    = (fill_inc >= {1'b0, len_q}) &&
               (((shifted ^ pat_q) & len_mask) == '0);
      if (hit) begin
        state_d = MATCH;
        // Non-overlapping mode: the next match must be built from fresh bits.
        if (!ovl_q) begin
          fill_d = '0;
        end
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = SEARCH;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN;
      ovl_q   <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.dout        = (state_q == MATCH);
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog
// Directed bench for seq_detect_prog (MAX_LEN=8, LEN_W=4, CNT_W=3). Each
// stimulus step pushes its hand-computed expected {dout, match_count, cfg_err}
// into a scoreboard queue tagged with the cycle it becomes visible; a separate
// monitor pops and compares on the falling edge once that cycle is reached.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 3;

  logic clk;
  logic reset;

  seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    due;
    string name;
    logic  dout;
    int    cnt;
    logic  err;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  // Monitor: compares one expected entry per cycle once its cycle is reached.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (bus.dout !== e.dout || int'(bus.match_count) != e.cnt ||
          $isunknown(bus.match_count) || bus.cfg_err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got dout=%b count=%0d cfg_err=%b, want dout=%b count=%0d cfg_err=%b",
                 e.name, bus.dout, bus.match_count, bus.cfg_err, e.dout, e.cnt, e.err);
      end
    end
  end

  task automatic step(input string nm, input bit rst, input bit vld, input bit d,
                      input bit ld, input logic [7:0] pat, input logic [3:0] len,
                      input bit ovl, input bit clr,
                      input bit ed, input int ec, input bit ee);
    exp_t e;
    @(negedge clk);
    reset           = rst;
    bus.din_valid   = vld;
    bus.din         = d;
    bus.cfg_load    = ld;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cnt_clr     = clr;
    e.due  = cyc + 1;
    e.name = nm;
    e.dout = ed;
    e.cnt  = ec;
    e.err  = ee;
    sb_q.push_back(e);
  endtask

  task automatic bit_in(input string nm, input bit d, input bit ed, input int ec);
    step(nm, 1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ed, ec, 1'b0);
  endtask

  task automatic idle(input string nm, input bit clr, input bit ed, input int ec);
    step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, clr, ed, ec, 1'b0);
  endtask

  task automatic load(input string nm, input logic [7:0] pat, input logic [3:0] len,
                      input bit ovl, input bit vld, input bit d, input bit clr,
                      input bit ed, input int ec, input bit ee);
    step(nm, 1'b0, vld, d, 1'b1, pat, len, ovl, clr, ed, ec, ee);
  endtask

  logic [15:0] a5a5;

  initial begin
    reset = 1'b1;
    bus.din_valid = 1'b0; bus.din = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cnt_clr = 1'b0;

    // Reset state
    step("reset0", 1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0);

    // Default overlapping 1010
    bit_in("ovl_b1", 1, 0, 0);
    bit_in("ovl_b2", 0, 0, 0);
    bit_in("ovl_b3", 1, 0, 0);
    bit_in("ovl_b4", 0, 1, 1);
    bit_in("ovl_b5", 1, 0, 1);
    bit_in("ovl_b6", 0, 1, 2);
    idle("ovl_clr", 1, 1, 0);

    // Non-overlap "11", back to back then with gaps
    load("ld11", 8'h03, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    bit_in("no_b1", 1, 0, 0);
    bit_in("no_b2", 1, 1, 1);
    bit_in("no_b3", 1, 0, 1);
    bit_in("no_b4", 1, 1, 2);
    load("ld11b", 8'h03, 4'd2, 0, 0, 0, 0, 0, 2, 0);
    bit_in("gap_b1", 1, 0, 2);
    idle("gap_i1", 0, 0, 2);
    bit_in("gap_b2", 1, 1, 3);
    idle("gap_i2", 0, 1, 3);
    bit_in("gap_b3", 1, 0, 3);
    idle("gap_i3", 0, 0, 3);
    bit_in("gap_b4", 1, 1, 4);
    idle("gap_clr", 1, 1, 0);

    // Full length 0xA5, overlap, stream A5A5 MSB first
    load("ldA5", 8'hA5, 4'd8, 1, 0, 0, 0, 0, 0, 0);
    a5a5 = 16'hA5A5;
    for (int k = 1; k <= 16; k++) begin
      bit_in($sformatf("a5_b%0d", k), a5a5[16-k], (k == 8 || k == 16),
             (k >= 16) ? 2 : ((k >= 8) ? 1 : 0));
    end

    // Illegal config loads; same-cycle bit dropped
    load("ld1010", 8'h0A, 4'd4, 1, 0, 0, 1, 0, 0, 0);
    bit_in("il_b1", 1, 0, 0);
    bit_in("il_b2", 0, 0, 0);
    bit_in("il_b3", 1, 0, 0);
    load("il_len0", 8'h0F, 4'd0, 0, 1, 0, 0, 0, 0, 1);
    bit_in("il_b4", 0, 1, 1);
    load("il_len9", 8'hFF, 4'd9, 0, 1, 1, 0, 1, 1, 1);
    bit_in("il_b5", 0, 0, 1);
    bit_in("il_b6", 1, 0, 1);
    bit_in("il_b7", 0, 0, 1);
    bit_in("il_b8", 1, 0, 1);
    bit_in("il_b9", 0, 1, 2);

    // Saturation at 7 and clear priority over a match
    idle("sat_clr", 1, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      bit_in($sformatf("sat%0d_1", i), 1, 0, (i - 1 > 7) ? 7 : i - 1);
      bit_in($sformatf("sat%0d_0", i), 0, 1, (i > 7) ? 7 : i);
    end
    bit_in("prio_b1", 1, 0, 7);
    step("clr_prio", 0, 1, 0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0);

    // Reset mid-pattern restores the default detector
    bit_in("pre_b1", 1, 0, 0);
    bit_in("pre_b2", 0, 1, 1);
    load("ld11c", 8'h03, 4'd2, 0, 0, 0, 0, 0, 1, 0);
    bit_in("mid_b1", 1, 0, 1);
    bit_in("mid_b2", 0, 0, 1);
    bit_in("mid_b3", 1, 0, 1);
    step("mid_rst", 1, 1, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0);
    bit_in("post_b0", 0, 0, 0);
    bit_in("post_b1", 1, 0, 0);
    bit_in("post_b2", 0, 0, 0);
    bit_in("post_b3", 1, 0, 0);
    bit_in("post_b4", 0, 1, 1);
    idle("post_idle", 0, 1, 1);

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
